// File: rtl/tt_cond_pkg.sv
// Input conditioner shared definitions.
// Default sizing and counter width helper.
package tt_cond_pkg;

  localparam int WIDTH_DEF       = 8;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int DEB_CYCLES_DEF  = 16;

  function automatic int cnt_width(input int deb);
    int w;
    w = $clog2(deb);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/tt_debounce_bit.sv
// One input bit: sync chain, debounce counter,
// accepted level and registered edge pulses.
module tt_debounce_bit
  import tt_cond_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DEB_CYCLES  = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic pulse_nxt
);

  localparam int CW = cnt_width(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;
  logic                   dout_d;
  logic                   rise_d;
  logic                   fall_d;

  assign s = sync_q[SYNC_STAGES-1];

  // Sync chain shifts regardless of ena.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  // Debounce next state; a match always restarts the count.
  always_comb begin
    cnt_d  = cnt_q;
    dout_d = dout;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (ena) begin
      if (s == dout) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        cnt_d  = '0;
        dout_d = s;
        rise_d = s;
        fall_d = ~s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Counter, level and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      dout  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      dout  <= dout_d;
      rise  <= rise_d;
      fall  <= fall_d;
    end
  end

  assign pulse_nxt = rise_d | fall_d;

endmodule

// File: rtl/tt_input_conditioner.sv
// Pad input conditioner: per-bit debounce
// with level, edge pulses and a change flag.
module tt_input_conditioner
  import tt_cond_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DEB_CYCLES  = DEB_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES must be 2..4");
  end
  if (DEB_CYCLES < 2 || DEB_CYCLES > 256) begin : g_bad_deb
    $error("DEB_CYCLES must be 2..256");
  end

  logic [WIDTH-1:0] pulse_nxt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    tt_debounce_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_CYCLES  (DEB_CYCLES)
    ) u_bit (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .din       (din[i]),
      .dout      (dout[i]),
      .rise      (rise[i]),
      .fall      (fall[i]),
      .pulse_nxt (pulse_nxt[i])
    );
  end

  // Registered OR of next pulses keeps changed aligned with rise/fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) changed <= 1'b0;
    else        changed <= |pulse_nxt;
  end

endmodule

// File: tb/tb_tt_input_conditioner.sv
// Bench for tt_input_conditioner: directed
// scenarios plus random stimulus vs a model.
module tb_tt_input_conditioner;

  localparam int W  = 8;
  localparam int SS = 2;
  localparam int DC = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ena;
  logic [W-1:0] din;
  logic [W-1:0] dout;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic         changed;

  int n_vec = 0;
  int n_bad = 0;

  logic [W-1:0] m_lvl;
  logic [W-1:0] m_rise;
  logic [W-1:0] m_fall;
  logic         m_chg;
  int           m_run [W];
  logic [W-1:0] m_hist [$];

  tt_input_conditioner #(
    .WIDTH       (W),
    .SYNC_STAGES (SS),
    .DEB_CYCLES  (DC)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .din     (din),
    .dout    (dout),
    .rise    (rise),
    .fall    (fall),
    .changed (changed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_lvl  = '0;
    m_rise = '0;
    m_fall = '0;
    m_chg  = 1'b0;
    for (int i = 0; i < W; i++) m_run[i] = 0;
    m_hist.delete();
    repeat (SS) m_hist.push_back('0);
  endtask

  // Level after a steady mismatch run of DC synced samples.
  task automatic m_edge(input logic [W-1:0] d, input logic e);
    logic [W-1:0] s;
    s = m_hist.pop_front();
    m_hist.push_back(d);
    m_rise = '0;
    m_fall = '0;
    if (e) begin
      for (int i = 0; i < W; i++) begin
        if (s[i] == m_lvl[i]) begin
          m_run[i] = 0;
        end else begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == DC) begin
            m_run[i] = 0;
            m_lvl[i] = s[i];
            if (s[i]) m_rise[i] = 1'b1;
            else      m_fall[i] = 1'b1;
          end
        end
      end
    end
    m_chg = |(m_rise | m_fall);
  endtask

  task automatic step(input logic [W-1:0] d, input logic e);
    din = d;
    ena = e;
    @(posedge clk);
    m_edge(d, e);
    #1;
    chk("dout", 32'(dout), 32'(m_lvl));
    chk("rise", 32'(rise), 32'(m_rise));
    chk("fall", 32'(fall), 32'(m_fall));
    chk("changed", 32'(changed), 32'(m_chg));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dout"}, 32'(dout), 32'h0);
    chk({tag, "_rise"}, 32'(rise), 32'h0);
    chk({tag, "_fall"}, 32'(fall), 32'h0);
    chk({tag, "_chg"}, 32'(changed), 32'h0);
  endtask

  initial begin
    int t_rise;
    int t_fall;
    int n_chg;
    int max_cnt;
    logic [W-1:0] d;

    rst_n = 1'b0;
    ena   = 1'b1;
    din   = '0;
    m_reset();
    #1;
    chk_zero("rst_init");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: reset mid-count, then release with FF held
    repeat (8) step(8'hFF, 1'b1);
    chk("t1_set", 32'(dout), 32'hFF);
    repeat (4) step(8'h00, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_zero("t1_async");
    m_reset();
    din = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("t1_held");
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step(8'hFF, 1'b1);
      if (k == 5) chk("t1_e5", 32'(dout), 32'h00);
      if (k == 6) chk("t1_e6", 32'(dout), 32'hFF);
    end

    // 2: clean edge on bit 0
    repeat (8) step(8'h00, 1'b1);
    for (int k = 1; k <= 7; k++) begin
      step(8'h01, 1'b1);
      if (k == 5) chk("t2_e5", 32'(dout), 32'h00);
      if (k == 6) begin
        chk("t2_rise", 32'(rise), 32'h01);
        chk("t2_chg", 32'(changed), 32'h1);
        chk("t2_fall", 32'(fall), 32'h00);
      end
      if (k == 7) chk("t2_rise_off", 32'(rise), 32'h00);
    end

    // 3: glitch of 3 cycles rejected, 4 accepted
    repeat (3) step(8'h09, 1'b1);
    repeat (8) step(8'h01, 1'b1);
    chk("t3_glitch", 32'(dout), 32'h01);
    t_rise = 0;
    t_fall = 0;
    for (int k = 1; k <= 14; k++) begin
      step((k <= 4) ? 8'h09 : 8'h01, 1'b1);
      if (rise[3]) t_rise = k;
      if (fall[3]) t_fall = k;
    end
    chk("t3_rise_at", 32'(t_rise), 32'd6);
    chk("t3_fall_at", 32'(t_fall), 32'd10);

    // 4: simultaneous rise on several bits
    repeat (8) step(8'h00, 1'b1);
    n_chg = 0;
    for (int k = 1; k <= 8; k++) begin
      step(8'hA5, 1'b1);
      if (changed) n_chg++;
      if (k == 6) chk("t4_rise", 32'(rise), 32'hA5);
    end
    chk("t4_nchg", 32'(n_chg), 32'd1);

    // 5: enable freeze mid-count on bit 1
    repeat (4) step(8'hA7, 1'b1);
    repeat (10) step(8'hA7, 1'b0);
    chk("t5_frozen", 32'(dout), 32'hA5);
    step(8'hA7, 1'b1);
    chk("t5_en1", 32'(dout), 32'hA5);
    step(8'hA7, 1'b1);
    chk("t5_en2", 32'(dout), 32'hA7);
    chk("t5_rise", 32'(rise), 32'h02);
    repeat (4) step(8'hA7, 1'b1);

    // 6: chatter on bit 2
    max_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      step((k % 2 == 0) ? 8'hA3 : 8'hA7, 1'b1);
      if (int'(u_dut.g_bit[2].u_bit.cnt_q) > max_cnt)
        max_cnt = int'(u_dut.g_bit[2].u_bit.cnt_q);
    end
    chk("t6_dout", 32'(dout), 32'hA7);
    chk("t6_maxcnt", 32'(max_cnt), 32'd1);

    // random: slow bit flips, occasional ena drop
    d = 8'hA7;
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < W; i++)
        if ($urandom_range(0, 5) == 0) d[i] = ~d[i];
      step(d, ($urandom_range(0, 7) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
